// File: rtl/hs_npu_output_packer.sv
// Packs a valid-qualified element stream into wide words and queues them in a small FIFO.
// The upstream path has no backpressure, so a word that cannot be queued is dropped and flagged.
module hs_npu_output_packer #(
   parameter int DATA_WIDTH     = 16,
   parameter int ELEMS_PER_WORD = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [DATA_WIDTH-1:0]                in_data,
   input  logic                                 in_valid,
   input  logic                                 flush,
   output logic [DATA_WIDTH*ELEMS_PER_WORD-1:0] out_data,
   output logic [ELEMS_PER_WORD-1:0]            out_mask,
   output logic                                 out_last,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 overflow,
   output logic                                 busy
);

   localparam int WW = DATA_WIDTH * ELEMS_PER_WORD;
   localparam int LW = $clog2(ELEMS_PER_WORD);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [WW-1:0]             r_asm;
   logic [LW-1:0]             r_lane_count;
   logic [WW-1:0]             r_fifo_data [FIFO_DEPTH];
   logic [ELEMS_PER_WORD-1:0] r_fifo_mask [FIFO_DEPTH];
   logic                      r_fifo_last [FIFO_DEPTH];
   logic [PW-1:0]             r_wr_ptr;
   logic [PW-1:0]             r_rd_ptr;
   logic [CW-1:0]             r_count;
   logic                      r_overflow;

   logic [WW-1:0]             w_word_data;
   logic [ELEMS_PER_WORD-1:0] w_word_mask;
   logic                      w_fill_last;
   logic                      w_close;
   logic                      w_full;
   logic                      w_out_valid;
   logic                      w_pop;
   logic                      w_push;

   // Candidate word = assembly register with this cycle's element merged into its lane.
   always_comb begin
      w_word_data = r_asm;
      w_word_mask = '0;
      for (int k = 0; k < ELEMS_PER_WORD; k++) begin
         if (in_valid && (r_lane_count == LW'(k))) begin
            w_word_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
            w_word_mask[k] = 1'b1;
         end else if (LW'(k) < r_lane_count) begin
            w_word_mask[k] = 1'b1;
         end
      end
   end

   assign w_fill_last = in_valid && (r_lane_count == LW'(ELEMS_PER_WORD - 1));
   assign w_close     = w_fill_last || flush;
   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_out_valid = (r_count != '0);
   assign w_pop       = w_out_valid && out_ready;
   assign w_push      = w_close && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_asm        <= '0;
         r_lane_count <= '0;
      end else if (w_close) begin
         r_asm        <= '0;
         r_lane_count <= '0;
      end else if (in_valid) begin
         r_asm        <= w_word_data;
         r_lane_count <= r_lane_count + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_mask[i] <= '0;
            r_fifo_last[i] <= 1'b0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_word_data;
            r_fifo_mask[r_wr_ptr] <= w_word_mask;
            r_fifo_last[r_wr_ptr] <= flush;
            r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // Sticky until reset: a closed word had nowhere to go.
         if (w_close && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign out_valid = w_out_valid;
   assign out_data  = w_out_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign out_mask  = w_out_valid ? r_fifo_mask[r_rd_ptr] : '0;
   assign out_last  = w_out_valid && r_fifo_last[r_rd_ptr];
   assign overflow  = r_overflow;
   assign busy      = (r_lane_count != '0) || w_out_valid;

endmodule

// File: doc/hs_npu_output_packer.md
# hs_npu_output_packer

Packs the narrow, valid-qualified result stream from the activation stage into wide words for the NPU output memory/bus. It sits directly downstream of the activation unit, which has no backpressure. The packer therefore absorbs stalls in a small word FIFO and reports lost data instead of stalling upstream. A flush closes a packet and marks its final word.

## Interface

**Parameters**
- `DATA_WIDTH`, 16: width of one result element; matches activation `OUTPUT_WIDTH`.
- `ELEMS_PER_WORD`, 4: elements per output word; must be ≥ 2.
- `FIFO_DEPTH`, 4: number of packed words buffered; must be ≥ 1.

**Ports**
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_data`, in, `DATA_WIDTH`: result element from the activation stage.
- `in_valid`, in, 1: element present. Always accepted; there is no ready.
- `flush`, in, 1: closes the current packet, emits the partial or terminator word, and marks it last.
- `out_data`, out, `DATA_WIDTH*ELEMS_PER_WORD`: packed word. Element k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `out_mask`, out, `ELEMS_PER_WORD`: bit k is 1 when lane k holds a real element.
- `out_last`, out, 1: word closes a packet.
- `out_valid`, out, 1: FIFO head present.
- `out_ready`, in, 1: downstream accepts the word.
- `overflow`, out, 1: sticky. Set when a word is dropped because the FIFO is full. Cleared only by `rst`.
- `busy`, out, 1: `lane_count != 0` or FIFO not empty.

## Operation

**State**
- Assembly register holding up to `ELEMS_PER_WORD-1` elements.
- `lane_count`, range 0..`ELEMS_PER_WORD-1`.
- FIFO of {data, mask, last} entries.
- `overflow` flag.

**Element accept**
- On `in_valid`, `in_data` is written to lane `lane_count`.
- Lanes fill in order 0, 1, 2, …; `lane_count` increments.

**Word close**
- A word closes when an element fills lane `ELEMS_PER_WORD-1`, or when `flush`=1.
- The closed word is pushed with mask = filled lanes. Unfilled lanes are 0.
- `last` = `flush`.
- After the push, `lane_count` returns to 0 and the assembly register clears to 0.

**Simultaneous `in_valid` and `flush`**
- The element is included first, then the word closes with `last`=1.
- If that element fills the final lane, exactly one word is pushed: mask all-ones, `last`=1. No extra terminator follows.

**Flush with `lane_count`=0 and no `in_valid`**
- Pushes a terminator word: data 0, mask 0, `last`=1.

**FIFO push and pop**
- Push succeeds if the FIFO is not full, or if it is full and a pop happens in the same cycle.
- Otherwise the closed word is dropped, `overflow` is set, and `lane_count` still resets to 0.
- The output is the FIFO head. A pop occurs when `out_valid && out_ready`.
- Words leave in push order.

**Reset**
- Reset mid-packet discards the assembly register and all FIFO contents.
- No word is emitted for discarded data.

## Timing

**Reset values**
- `out_valid`=0, `out_data`=0, `out_mask`=0, `out_last`=0.
- `overflow`=0, `busy`=0, `lane_count`=0.

**Latency**
- A closing event in cycle N (the element or `flush` sampled at edge N) makes the word visible on `out_valid`/`out_data` after edge N, i.e. during cycle N+1, provided the FIFO was empty.

**Throughput**
- One element per cycle sustained.
- One word per cycle out.

**Handshake**
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_mask` and `out_last` hold stable.
- `out_valid` never deasserts without a transfer, except on `rst`.
- `out_valid` does not depend combinationally on `out_ready`.

**Other rules**
- `overflow` rises in cycle N+1 after the dropped push at edge N.
- `busy` is registered-state derived: it goes low the cycle after the last pop, provided `lane_count`=0.

## Test plan

1. **Full word:** `out_ready`=1; elements 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles → one cycle after the 4th element: `out_data`=0x0004_0003_0002_0001, `out_mask`=4'b1111, `out_last`=0, one-cycle `out_valid` pulse.
2. **Partial flush:** 0xAAAA, 0xBBBB, then `flush` alone → `out_data`=0x0000_0000_BBBB_AAAA, `out_mask`=4'b0011, `out_last`=1; `busy` returns to 0 one cycle after the transfer.
3. **Flush edge cases:**
   - `flush` with an empty assembly → terminator word: data 0, mask 4'b0000, last 1.
   - 3 elements, then the 4th element together with `flush` → a single word, mask 4'b1111, last 1, and no following terminator.
4. **Backpressure and overflow:** `out_ready`=0; 20 elements with values 0..19 → 4 words buffered, the 5th word (16..19) dropped, `overflow`=1. Then `out_ready`=1 → words 0–3, 4–7, 8–11, 12–15 drain in order with stable data during the stall; `overflow` stays 1.
5. **Full FIFO with concurrent pop:** FIFO full, `out_ready`=1 in the same cycle the next word closes → no drop, `overflow` stays 0, data ordering preserved.
6. **Reset mid-packet:** 2 elements queued plus 2 words in the FIFO, `rst` for 1 cycle → all outputs at reset values the next cycle. A following 4-element sequence 0x0011..0x0014 emits exactly 0x0014_0013_0012_0011 with mask 4'b1111.
